cpu_core: RTL and testbench
===========================

// Module: cpu_core
// PURPOSE
// - Multi-cycle 16-bit load/store CPU: 16 x 16-bit registers, r0 hard-wired to 0.
// - Fetches from an external dual-read synchronous instruction memory
//   (data_0 = mem[addr], data_1 = mem[addr+1], both valid 1 cycle after addr).
// - Accesses an external single-port synchronous data memory (1-cycle read latency).
// - Exchanges words with accelerators over a simple valid/ready-style port.
// PARAMETERS
// - INSTRUCTION_WIDTH    16    instruction word width
// - IMEM_ADDR_WIDTH      10    instruction address width (1024 words)
// - DATA_WIDTH           16    register and data word width
// - DMEM_ADDR_WIDTH      10    data address width (1024 words)
// - ACCEL_ID_WIDTH        4    accelerator select width
// PORTS
// - clk                    in   1    single clock, rising edge
// - rst                    in   1    asynchronous, active-low reset
// - instr_mem_addr         out  10   word address = pc
// - instr_mem_data_0       in   16   instruction word at pc
// - instr_mem_data_1       in   16   word at pc+1 (immediate / target)
// - data_mem_addr          out  10   data address = rs1[9:0]
// - data_mem_read_data     in   16   load data, valid 1 cycle after addr
// - data_mem_write_enable  out  1    store strobe
// - data_mem_write_data    out  16   store data
// - accel_id               out  4    accelerator select
// - accel_can_read         in   1    accelerator has data available
// - accel_can_write        in   1    accelerator accepts data
// - accel_read_enable      out  1    1-cycle pop strobe
// - accel_read_data        in   16   accelerator read data
// - accel_write_enable     out  1    1-cycle push strobe
// - accel_write_data       out  16   accelerator write data
// BEHAVIOUR
// - Encoding: op[15:12] rd[11:8] rs1[7:4] rs2[3:0].
// - ALU ops: rd = rs1 OP rs2, modulo 2^16.
//   - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
//   - 5 SHL, 6 SHR (logical); shift amount = rs2[3:0].
//   - 7 MUL (low 16 bits).
// - 8 LI: rd = data_1; pc += 2.
// - 9 LD: rd = dmem[rs1].
// - A ST: dmem[rs1] = rd.
// - B BEQ: if rs1 == rs2 then pc = data_1, else pc += 2.
// - C BNE: if rs1 != rs2 then pc = data_1, else pc += 2.
// - D JMP: pc = data_1.
// - E ACCRD: accel_id = rs1 field (constant); rd = accel_read_data.
// - F ACCWR: accel_id = rs1 field (constant); push rd.
// - All other ops advance pc += 1.
// - Writes to r0 are discarded; r0 always reads 0. All-zero word = NOP.
// - FSM: FETCH -> EXEC (-> LDWAIT for LD).
//   - FETCH: 1 cycle, instr_mem_addr = pc.
//   - EXEC: decode data_0/data_1, write back or strobe, update pc.
//   - Latency: 2 cycles per instruction; LD takes 3 (write back in LDWAIT).
// - ACCRD/ACCWR stall in EXEC while accel_can_read / accel_can_write is low.
//   - Strobe asserted for exactly the cycle the instruction completes.
//   - accel_read_data is sampled in that same cycle.
// - executed: 16-bit counter, +1 on each instruction completion, wraps.
// - pc wraps modulo 1024; data_1 at pc = 1023 comes from address 0.
// - Register write port: rd2 / rd2_write_enable / rd2_write_data.
//   - Commits on the clock edge ending the completing cycle.
// - Reset (rst = 0, async), regardless of state or stall:
//   - pc = 0, executed = 0, state = FETCH.
//   - All strobes low; data_mem_addr, write data and accel_id = 0.
//   - Register contents are not reset; the bench clears them.
// - Release mid-stall restarts by fetching at 0.
// TESTING
// - Per-cycle state trace (executed, pc, r1..r15) dumped at each negedge.
// - Trace must match the reference model over 1000 cycles for random programs.
// - LI r1,0x1234; ADD r2,r1,r1 -> r1 = 4660, r2 = 9320; executed = 2 after 4 cycles.
// - SUB r3,r0,r1 with r1 = 1 -> r3 = 65535; ADD r0,r1,r1 leaves r0 = 0.
// - ST r1 -> [r2 = 5], then LD r4,[r2] -> r4 = r1; LD completes in 3 cycles.
// - BEQ r0,r0,40 -> pc = 40; BNE r0,r0,40 at pc = 10 -> pc = 12.
// - ACCRD with accel_read_data = 42 and can_read = 1 -> rd = 42, one read_enable pulse.
// - ACCRD with can_read = 0 for 3 cycles -> pc and executed hold until it rises.
// - Reset asserted mid-LD -> pc = 0, executed = 0, no write strobe issued.

Source files
------------

// File: rtl/cpu_core.sv
`default_nettype none
// ============================================================================
// cpu_core : multi-cycle 16-bit load/store CPU (FETCH -> EXEC -> LDWAIT)
// Revision : 1.0
// ============================================================================
module cpu_core #(
  parameter int INSTRUCTION_WIDTH = 16,
  parameter int IMEM_ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH        = 16,
  parameter int DMEM_ADDR_WIDTH   = 10,
  parameter int ACCEL_ID_WIDTH    = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic [IMEM_ADDR_WIDTH-1:0]   instr_mem_addr,
  input  logic [INSTRUCTION_WIDTH-1:0] instr_mem_data_0,
  input  logic [INSTRUCTION_WIDTH-1:0] instr_mem_data_1,
  output logic [DMEM_ADDR_WIDTH-1:0]   data_mem_addr,
  input  logic [DATA_WIDTH-1:0]        data_mem_read_data,
  output logic                         data_mem_write_enable,
  output logic [DATA_WIDTH-1:0]        data_mem_write_data,
  output logic [ACCEL_ID_WIDTH-1:0]    accel_id,
  input  logic                         accel_can_read,
  input  logic                         accel_can_write,
  output logic                         accel_read_enable,
  input  logic [DATA_WIDTH-1:0]        accel_read_data,
  output logic                         accel_write_enable,
  output logic [DATA_WIDTH-1:0]        accel_write_data
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_EXEC   = 2'd1,
    S_LDWAIT = 2'd2
  } state_t;

  localparam logic [3:0] c_op_add   = 4'h0;
  localparam logic [3:0] c_op_sub   = 4'h1;
  localparam logic [3:0] c_op_and   = 4'h2;
  localparam logic [3:0] c_op_or    = 4'h3;
  localparam logic [3:0] c_op_xor   = 4'h4;
  localparam logic [3:0] c_op_shl   = 4'h5;
  localparam logic [3:0] c_op_shr   = 4'h6;
  localparam logic [3:0] c_op_mul   = 4'h7;
  localparam logic [3:0] c_op_li    = 4'h8;
  localparam logic [3:0] c_op_ld    = 4'h9;
  localparam logic [3:0] c_op_st    = 4'hA;
  localparam logic [3:0] c_op_beq   = 4'hB;
  localparam logic [3:0] c_op_bne   = 4'hC;
  localparam logic [3:0] c_op_jmp   = 4'hD;
  localparam logic [3:0] c_op_accrd = 4'hE;
  localparam logic [3:0] c_op_accwr = 4'hF;

  state_t                       r_state;
  logic [IMEM_ADDR_WIDTH-1:0]   r_pc;
  logic [15:0]                  r_executed;
  logic [3:0]                   r_ld_rd;
  logic [DATA_WIDTH-1:0]        r_regs [16];

  logic [3:0]                   w_op;
  logic [3:0]                   w_rd;
  logic [3:0]                   w_rs1;
  logic [3:0]                   w_rs2;
  logic [DATA_WIDTH-1:0]        w_rd_val;
  logic [DATA_WIDTH-1:0]        w_rs1_val;
  logic [DATA_WIDTH-1:0]        w_rs2_val;
  logic [DATA_WIDTH-1:0]        w_alu;
  logic [IMEM_ADDR_WIDTH-1:0]   w_pc_next;
  logic                         w_exec;
  logic                         w_stall;
  logic                         w_exec_done;
  logic [3:0]                   w_rd2;
  logic                         w_rd2_write_enable;
  logic [DATA_WIDTH-1:0]        w_rd2_write_data;

  assign w_op  = instr_mem_data_0[15:12];
  assign w_rd  = instr_mem_data_0[11:8];
  assign w_rs1 = instr_mem_data_0[7:4];
  assign w_rs2 = instr_mem_data_0[3:0];

  // r0 is never written, so the read side forces it to zero
  assign w_rd_val  = (w_rd  == 4'd0) ? '0 : r_regs[w_rd];
  assign w_rs1_val = (w_rs1 == 4'd0) ? '0 : r_regs[w_rs1];
  assign w_rs2_val = (w_rs2 == 4'd0) ? '0 : r_regs[w_rs2];

  always_comb begin
    w_alu = '0;
    case (w_op)
      c_op_add: w_alu = w_rs1_val + w_rs2_val;
      c_op_sub: w_alu = w_rs1_val - w_rs2_val;
      c_op_and: w_alu = w_rs1_val & w_rs2_val;
      c_op_or:  w_alu = w_rs1_val | w_rs2_val;
      c_op_xor: w_alu = w_rs1_val ^ w_rs2_val;
      c_op_shl: w_alu = w_rs1_val << w_rs2_val[3:0];
      c_op_shr: w_alu = w_rs1_val >> w_rs2_val[3:0];
      c_op_mul: w_alu = w_rs1_val * w_rs2_val;
      default:  w_alu = '0;
    endcase
  end

  assign w_exec      = (r_state == S_EXEC);
  assign w_stall     = w_exec && (((w_op == c_op_accrd) && !accel_can_read) ||
                                  ((w_op == c_op_accwr) && !accel_can_write));
  assign w_exec_done = w_exec && !w_stall && (w_op != c_op_ld);

  always_comb begin
    w_pc_next = r_pc + IMEM_ADDR_WIDTH'(1);
    case (w_op)
      c_op_li:  w_pc_next = r_pc + IMEM_ADDR_WIDTH'(2);
      c_op_beq: w_pc_next = (w_rs1_val == w_rs2_val) ?
                            instr_mem_data_1[IMEM_ADDR_WIDTH-1:0] : r_pc + IMEM_ADDR_WIDTH'(2);
      c_op_bne: w_pc_next = (w_rs1_val != w_rs2_val) ?
                            instr_mem_data_1[IMEM_ADDR_WIDTH-1:0] : r_pc + IMEM_ADDR_WIDTH'(2);
      c_op_jmp: w_pc_next = instr_mem_data_1[IMEM_ADDR_WIDTH-1:0];
      default:  w_pc_next = r_pc + IMEM_ADDR_WIDTH'(1);
    endcase
  end

  always_comb begin
    w_rd2              = w_rd;
    w_rd2_write_enable = 1'b0;
    w_rd2_write_data   = w_alu;
    if (r_state == S_LDWAIT) begin
      w_rd2              = r_ld_rd;
      w_rd2_write_enable = 1'b1;
      w_rd2_write_data   = data_mem_read_data;
    end else if (w_exec_done) begin
      if (!w_op[3]) begin
        w_rd2_write_enable = 1'b1;
      end else if (w_op == c_op_li) begin
        w_rd2_write_enable = 1'b1;
        w_rd2_write_data   = instr_mem_data_1;
      end else if (w_op == c_op_accrd) begin
        w_rd2_write_enable = 1'b1;
        w_rd2_write_data   = accel_read_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_rd2_write_enable && (w_rd2 != 4'd0)) begin
      r_regs[w_rd2] <= w_rd2_write_data;
    end
  end

  // Memory and accelerator strobes are driven straight from EXEC decode so the
  // synchronous memories sample them at the edge that completes the cycle.
  assign instr_mem_addr        = r_pc;
  assign data_mem_addr         = (w_exec && ((w_op == c_op_ld) || (w_op == c_op_st))) ?
                                 w_rs1_val[DMEM_ADDR_WIDTH-1:0] : '0;
  assign data_mem_write_enable = w_exec && (w_op == c_op_st);
  assign data_mem_write_data   = data_mem_write_enable ? w_rd_val : '0;
  assign accel_id              = (w_exec && ((w_op == c_op_accrd) || (w_op == c_op_accwr))) ?
                                 ACCEL_ID_WIDTH'(w_rs1) : '0;
  assign accel_read_enable     = w_exec_done && (w_op == c_op_accrd);
  assign accel_write_enable    = w_exec_done && (w_op == c_op_accwr);
  assign accel_write_data      = accel_write_enable ? w_rd_val : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_FETCH;
      r_pc       <= '0;
      r_executed <= '0;
      r_ld_rd    <= '0;
    end else begin
      case (r_state)
        S_FETCH: r_state <= S_EXEC;
        S_EXEC: begin
          if (w_op == c_op_ld) begin
            r_ld_rd <= w_rd;
            r_state <= S_LDWAIT;
          end else if (!w_stall) begin
            r_pc       <= w_pc_next;
            r_executed <= r_executed + 16'd1;
            r_state    <= S_FETCH;
          end
        end
        S_LDWAIT: begin
          r_pc       <= r_pc + IMEM_ADDR_WIDTH'(1);
          r_executed <= r_executed + 16'd1;
          r_state    <= S_FETCH;
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_core.sv
`default_nettype none
// ============================================================================
// tb_cpu_core : directed self-checking bench for cpu_core
// Revision    : 1.0
// ============================================================================
module tb_cpu_core;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [9:0]  instr_mem_addr;
  logic [15:0] instr_mem_data_0;
  logic [15:0] instr_mem_data_1;
  logic [9:0]  data_mem_addr;
  logic [15:0] data_mem_read_data;
  logic        data_mem_write_enable;
  logic [15:0] data_mem_write_data;
  logic [3:0]  accel_id;
  logic        accel_can_read = 1'b0;
  logic        accel_can_write = 1'b0;
  logic        accel_read_enable;
  logic [15:0] accel_read_data = 16'h0;
  logic        accel_write_enable;
  logic [15:0] accel_write_data;

  logic [15:0] imem [1024];
  logic [15:0] dmem [1024];
  logic [9:0]  imem_addr_p1;

  int checks = 0;
  int failures = 0;
  int rd_pulses = 0;
  int wr_pulses = 0;
  int st_pulses = 0;
  logic [15:0] last_wr_data = 16'h0;
  logic [3:0]  last_wr_id = 4'h0;

  cpu_core dut (
    .clk                   (clk),
    .rst                   (rst),
    .instr_mem_addr        (instr_mem_addr),
    .instr_mem_data_0      (instr_mem_data_0),
    .instr_mem_data_1      (instr_mem_data_1),
    .data_mem_addr         (data_mem_addr),
    .data_mem_read_data    (data_mem_read_data),
    .data_mem_write_enable (data_mem_write_enable),
    .data_mem_write_data   (data_mem_write_data),
    .accel_id              (accel_id),
    .accel_can_read        (accel_can_read),
    .accel_can_write       (accel_can_write),
    .accel_read_enable     (accel_read_enable),
    .accel_read_data       (accel_read_data),
    .accel_write_enable    (accel_write_enable),
    .accel_write_data      (accel_write_data)
  );

  always #5 clk = ~clk;

  assign imem_addr_p1 = instr_mem_addr + 10'd1;

  always @(posedge clk) begin
    instr_mem_data_0 <= imem[instr_mem_addr];
    instr_mem_data_1 <= imem[imem_addr_p1];
    if (data_mem_write_enable) dmem[data_mem_addr] <= data_mem_write_data;
    data_mem_read_data <= dmem[data_mem_addr];
  end

  always @(posedge clk) begin
    if (accel_read_enable) rd_pulses++;
    if (data_mem_write_enable) st_pulses++;
    if (accel_write_enable) begin
      wr_pulses++;
      last_wr_data = accel_write_data;
      last_wr_id   = accel_id;
    end
  end

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp;
  } alu_vec_t;

  alu_vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 1024; i++) imem[i] = 16'h0000;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    accel_can_read  = 1'b0;
    accel_can_write = 1'b0;
    accel_read_data = 16'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int rd0, wr0, st0;

    vecs[0]  = '{4'h0, 16'h1234, 16'h1234, 16'h2468};
    vecs[1]  = '{4'h0, 16'hFFFF, 16'h0002, 16'h0001};
    vecs[2]  = '{4'h1, 16'h0000, 16'h0001, 16'hFFFF};
    vecs[3]  = '{4'h1, 16'h1000, 16'h0001, 16'h0FFF};
    vecs[4]  = '{4'h2, 16'hF0F0, 16'h3C3C, 16'h3030};
    vecs[5]  = '{4'h3, 16'hF0F0, 16'h0F01, 16'hFFF1};
    vecs[6]  = '{4'h4, 16'hAAAA, 16'hFFFF, 16'h5555};
    vecs[7]  = '{4'h5, 16'h0001, 16'h0013, 16'h0008};
    vecs[8]  = '{4'h6, 16'h8000, 16'h000F, 16'h0001};
    vecs[9]  = '{4'h6, 16'h8000, 16'h0010, 16'h8000};
    vecs[10] = '{4'h7, 16'h0100, 16'h0100, 16'h0000};
    vecs[11] = '{4'h7, 16'h1234, 16'h0003, 16'h369C};

    for (int i = 0; i < 1024; i++) dmem[i] = 16'h0000;
    clear_imem();

    // Reset state while held in reset
    repeat (3) @(posedge clk);
    #1;
    check("reset_pc", dut.r_pc, 0);
    check("reset_executed", dut.r_executed, 0);
    check("reset_strobes", {data_mem_write_enable, accel_read_enable, accel_write_enable}, 0);
    check("reset_dmem_addr", data_mem_addr, 0);
    check("reset_wdata_id", {data_mem_write_data, accel_write_data, accel_id}, 0);

    // ALU table: LI r1,a ; LI r2,b ; OP r3,r1,r2 ; JMP 5
    for (int i = 0; i < 12; i++) begin
      clear_imem();
      imem[0] = 16'h8100; imem[1] = vecs[i].a;
      imem[2] = 16'h8200; imem[3] = vecs[i].b;
      imem[4] = {vecs[i].op, 4'd3, 4'd1, 4'd2};
      imem[5] = 16'hD000; imem[6] = 16'h0005;
      apply_reset();
      run(6);
      check($sformatf("alu%0d_r3", i), dut.r_regs[3], vecs[i].exp);
      check($sformatf("alu%0d_exec_pc", i), {dut.r_executed, 6'd0, dut.r_pc}, {16'd3, 16'd5});
    end

    // LI r1,0x1234 ; ADD r2,r1,r1
    clear_imem();
    imem[0] = 16'h8100; imem[1] = 16'h1234; imem[2] = 16'h0211;
    imem[3] = 16'hD000; imem[4] = 16'h0003;
    apply_reset();
    run(4);
    check("li_add_r1", dut.r_regs[1], 16'd4660);
    check("li_add_r2", dut.r_regs[2], 16'd9320);
    check("li_add_executed", dut.r_executed, 2);

    // SUB r3,r0,r1 ; ADD r0,r1,r1 ; ADD r4,r0,r0
    clear_imem();
    imem[0] = 16'h8100; imem[1] = 16'h0001; imem[2] = 16'h1301;
    imem[3] = 16'h0011; imem[4] = 16'h0400; imem[5] = 16'hD000; imem[6] = 16'h0005;
    apply_reset();
    run(8);
    check("sub_r0_r3", dut.r_regs[3], 16'hFFFF);
    check("r0_stays_zero", dut.r_regs[4], 16'h0000);
    check("r0_exec_pc", {dut.r_executed, 6'd0, dut.r_pc}, {16'd4, 16'd5});

    // ST r1,[r2=5] ; LD r4,[r2]
    clear_imem();
    imem[0] = 16'h8100; imem[1] = 16'hBEEF; imem[2] = 16'h8200; imem[3] = 16'h0005;
    imem[4] = 16'hA120; imem[5] = 16'h9420; imem[6] = 16'hD000; imem[7] = 16'h0006;
    apply_reset();
    st0 = st_pulses;
    run(6);
    check("st_executed", dut.r_executed, 3);
    check("st_one_strobe", st_pulses - st0, 1);
    check("st_dmem5", dmem[5], 16'hBEEF);
    run(2);
    check("ld_not_done_after_2", dut.r_executed, 3);
    run(1);
    check("ld_done_after_3", dut.r_executed, 4);
    check("ld_r4", dut.r_regs[4], 16'hBEEF);
    check("ld_pc", dut.r_pc, 6);

    // Branches
    clear_imem();
    imem[0]   = 16'hB000; imem[1]   = 16'h0028;
    imem[40]  = 16'hD000; imem[41]  = 16'h000A;
    imem[10]  = 16'hC000; imem[11]  = 16'h0028;
    imem[12]  = 16'h8107; imem[13]  = 16'h0007;
    imem[14]  = 16'hC010; imem[15]  = 16'h0064;
    imem[100] = 16'hD000; imem[101] = 16'h0064;
    apply_reset();
    run(2);
    check("beq_taken_pc", dut.r_pc, 40);
    run(2);
    check("jmp_pc", dut.r_pc, 10);
    run(2);
    check("bne_not_taken_pc", dut.r_pc, 12);
    run(4);
    check("bne_taken_pc", dut.r_pc, 100);
    check("branch_executed", dut.r_executed, 5);

    // pc wrap: LI at 1023 takes its immediate from address 0
    clear_imem();
    imem[0] = 16'hD000; imem[1] = 16'h03FF; imem[1023] = 16'h8500;
    imem[2] = 16'hD000; imem[3] = 16'h0002;
    apply_reset();
    run(2);
    check("wrap_jmp_pc", dut.r_pc, 1023);
    run(2);
    check("wrap_li_pc", dut.r_pc, 1);
    check("wrap_li_r5", dut.r_regs[5], 16'hD000);

    // ACCRD ready immediately
    clear_imem();
    imem[0] = 16'hE170; imem[1] = 16'hD000; imem[2] = 16'h0001;
    apply_reset();
    accel_can_read  = 1'b1;
    accel_read_data = 16'd42;
    rd0 = rd_pulses;
    run(1);
    check("accrd_id_strobe", {accel_id, 3'd0, accel_read_enable}, {4'd7, 4'd1});
    run(1);
    check("accrd_r1", dut.r_regs[1], 16'd42);
    check("accrd_one_pulse", rd_pulses - rd0, 1);
    check("accrd_executed", dut.r_executed, 1);

    // ACCRD stalled for 3 cycles
    clear_imem();
    imem[0] = 16'hE270; imem[1] = 16'hD000; imem[2] = 16'h0001;
    apply_reset();
    rd0 = rd_pulses;
    run(1);
    for (int c = 0; c < 3; c++) begin
      run(1);
      check($sformatf("accrd_stall%0d", c),
            {dut.r_executed, 6'd0, dut.r_pc, 7'd0, accel_read_enable}, 0);
    end
    accel_can_read  = 1'b1;
    accel_read_data = 16'h55AA;
    run(1);
    check("accrd_stall_r2", dut.r_regs[2], 16'h55AA);
    check("accrd_stall_exec_pc", {dut.r_executed, 6'd0, dut.r_pc}, {16'd1, 16'd1});
    check("accrd_stall_one_pulse", rd_pulses - rd0, 1);

    // ACCWR stalled for 2 cycles
    clear_imem();
    imem[0] = 16'h8300; imem[1] = 16'h0C0C; imem[2] = 16'hF390;
    imem[3] = 16'hD000; imem[4] = 16'h0003;
    apply_reset();
    wr0 = wr_pulses;
    run(4);
    check("accwr_stalled", {dut.r_executed, 7'd0, accel_write_enable}, {16'd1, 8'd0});
    accel_can_write = 1'b1;
    #1;
    check("accwr_strobe", {accel_id, 3'd0, accel_write_enable, accel_write_data}, {4'd9, 4'd1, 16'h0C0C});
    run(1);
    check("accwr_pushed", {last_wr_id, last_wr_data}, {4'd9, 16'h0C0C});
    check("accwr_one_pulse", wr_pulses - wr0, 1);
    check("accwr_exec_pc", {dut.r_executed, 6'd0, dut.r_pc}, {16'd2, 16'd3});

    // Reset asserted while in LDWAIT
    clear_imem();
    imem[0] = 16'h8400; imem[1] = 16'h7777; imem[2] = 16'h8200; imem[3] = 16'h0005;
    imem[4] = 16'h9420; imem[5] = 16'hA420; imem[6] = 16'hD000; imem[7] = 16'h0006;
    apply_reset();
    run(6);
    check("mid_ld_in_ldwait", {dut.r_executed, 14'd0, dut.r_state}, {16'd2, 16'd2});
    st0 = st_pulses;
    rst = 1'b0;
    #1;
    check("mid_ld_async_reset", {dut.r_executed, 6'd0, dut.r_pc}, 0);
    check("mid_ld_no_strobe", {data_mem_write_enable, accel_read_enable, accel_write_enable}, 0);
    run(2);
    check("mid_ld_r4_kept", dut.r_regs[4], 16'h7777);
    check("mid_ld_no_store", st_pulses - st0, 0);
    @(negedge clk);
    rst = 1'b1;
    run(2);
    check("mid_ld_restart", {dut.r_executed, 6'd0, dut.r_pc}, {16'd1, 16'd2});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
